// File: rtl/range_report_packetizer.sv
// range_report_packetizer: tags 256-bit peak reports with the chirp id, buffers them
// in a small FIFO and serialises each as a 64-bit AXIS packet (6 beats, or 7 with a
// trailing checksum beat when REPORT_CHECKSUM_EN is defined).
// The head FIFO entry stays resident while its packet is on the wire and is released
// on the final-beat handshake, so the FIFO depth bounds all outstanding reports.
module range_report_packetizer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] MAGIC      = 32'h504b504b,
    parameter int unsigned SEQ_WIDTH  = 32
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [255:0] s_pk_axis_tdata,
    input  logic         s_pk_axis_tvalid,
    input  logic         s_pk_axis_tlast,
    output logic         s_pk_axis_tready,
    input  logic         iq_first,
    input  logic [63:0]  counter_id,
    output logic [63:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    output logic [7:0]   m_axis_tkeep,
    input  logic         m_axis_tready,
    output logic [31:0]  drop_count,
    output logic [31:0]  report_count
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 320;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_HDR, S_ID, S_PL0, S_PL1, S_PL2, S_PL3
`ifdef REPORT_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t               state, state_d;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [63:0]          id_r;
    logic [ENTRY_W-1:0]   hold;
    logic [SEQ_WIDTH-1:0] seq;
    logic [63:0]          tdata_d;
    logic                 tvalid_d, tlast_d;
    logic                 pop, load_hold, finish;
    logic                 wr_req, full, wr_en, drop, hs;
    logic [63:0]          hold_id;
    logic [255:0]         hold_data;
    logic [63:0]          hdr_word;
    logic                 unused_tlast;

    assign unused_tlast = s_pk_axis_tlast;
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign wr_req    = s_pk_axis_tvalid && s_pk_axis_tready;
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign wr_en     = wr_req && (!full || pop);
    assign drop      = wr_req && full && !pop;
    assign hold_id   = hold[319:256];
    assign hold_data = hold[255:0];
    assign hdr_word  = {MAGIC, 32'(seq)};

    // Report storage array (data only, pointers carry the reset state)
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {id_r, s_pk_axis_tdata};
    end

    // FIFO pointers, occupancy, latched chirp id and hold register
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            id_r   <= '0;
            hold   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
            if (iq_first)  id_r <= counter_id;
            if (load_hold) hold <= mem[rd_ptr];
        end
    end

    // FSM state, registered beat outputs and counters
    always_ff @(posedge aclk) begin
        if (areset) begin
            state            <= S_IDLE;
            m_axis_tdata     <= '0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tlast     <= 1'b0;
            m_axis_tkeep     <= '0;
            s_pk_axis_tready <= 1'b0;
            seq              <= '0;
            report_count     <= '0;
            drop_count       <= '0;
        end else begin
            state            <= state_d;
            m_axis_tdata     <= tdata_d;
            m_axis_tvalid    <= tvalid_d;
            m_axis_tlast     <= tlast_d;
            m_axis_tkeep     <= tvalid_d ? 8'hFF : 8'h00;
            s_pk_axis_tready <= 1'b1;
            if (finish) begin
                seq          <= seq + SEQ_WIDTH'(1);
                report_count <= report_count + 32'd1;
            end
            if (drop && (drop_count != 32'hFFFF_FFFF)) drop_count <= drop_count + 32'd1;
        end
    end

    // Next-state and next-beat selection; data states advance only on handshake
    always_comb begin
        state_d   = state;
        tdata_d   = m_axis_tdata;
        tvalid_d  = m_axis_tvalid;
        tlast_d   = m_axis_tlast;
        load_hold = 1'b0;
        finish    = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE: if (count != '0) begin
                load_hold = 1'b1;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                state_d  = S_HDR;
                tdata_d  = hdr_word;
                tvalid_d = 1'b1;
                tlast_d  = 1'b0;
            end
            S_HDR: if (hs) begin state_d = S_ID;  tdata_d = hold_id;           end
            S_ID:  if (hs) begin state_d = S_PL0; tdata_d = hold_data[63:0];   end
            S_PL0: if (hs) begin state_d = S_PL1; tdata_d = hold_data[127:64]; end
            S_PL1: if (hs) begin state_d = S_PL2; tdata_d = hold_data[191:128]; end
            S_PL2: if (hs) begin
                state_d = S_PL3;
                tdata_d = hold_data[255:192];
`ifdef REPORT_CHECKSUM_EN
                tlast_d = 1'b0;
`else
                tlast_d = 1'b1;
`endif
            end
`ifdef REPORT_CHECKSUM_EN
            S_PL3: if (hs) begin
                state_d = S_CSUM;
                tdata_d = hdr_word ^ hold_id ^ hold_data[63:0] ^ hold_data[127:64]
                        ^ hold_data[191:128] ^ hold_data[255:192];
                tlast_d = 1'b1;
            end
            S_CSUM: if (hs) finish = 1'b1;
`else
            S_PL3: if (hs) finish = 1'b1;
`endif
            default: state_d = S_IDLE;
        endcase
        // Final beat accepted: release the FIFO head and go idle
        if (finish) begin
            state_d  = S_IDLE;
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            pop      = 1'b1;
        end
    end

endmodule

// File: tb/tb_range_report_packetizer.sv
// Directed bench for range_report_packetizer; follows REPORT_CHECKSUM_EN if defined.
module tb_range_report_packetizer;

    localparam logic [31:0] MAGIC = 32'h504b504b;
`ifdef REPORT_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic         clk;
    logic         areset;
    logic [255:0] s_tdata;
    logic         s_tvalid, s_tlast, s_tready;
    logic         iq_first;
    logic [63:0]  counter_id;
    logic [63:0]  m_tdata;
    logic         m_tvalid, m_tlast, m_tready;
    logic [7:0]   m_tkeep;
    logic [31:0]  drop_count, report_count;

    int checks = 0;
    int errors = 0;
    int tlast_cnt = 0;
    logic [64:0] cap [$];

    range_report_packetizer dut (
        .aclk(clk), .areset(areset),
        .s_pk_axis_tdata(s_tdata), .s_pk_axis_tvalid(s_tvalid),
        .s_pk_axis_tlast(s_tlast), .s_pk_axis_tready(s_tready),
        .iq_first(iq_first), .counter_id(counter_id),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tkeep(m_tkeep), .m_axis_tready(m_tready),
        .drop_count(drop_count), .report_count(report_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output beat that will be accepted at the coming edge
    always @(negedge clk) begin
        if (!areset && m_tvalid && m_tready) begin
            cap.push_back({m_tlast, m_tdata});
            if (m_tlast) tlast_cnt <= tlast_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
        step();
        cap.delete();
    endtask

    task automatic send(input logic [255:0] d);
        s_tvalid = 1'b1;
        s_tdata  = d;
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({tag, ".beats_arrived"}, 64'(cap.size() >= n), 64'd1);
    endtask

    task automatic check_pkt(input string tag, input logic [31:0] sq,
                             input logic [63:0] id, input logic [255:0] d);
        logic [63:0] eb [NB];
        logic [64:0] w;
        eb[0] = {MAGIC, sq};
        eb[1] = id;
        for (int i = 0; i < 4; i++) eb[2+i] = d[64*i +: 64];
`ifdef REPORT_CHECKSUM_EN
        eb[6] = eb[0] ^ eb[1] ^ eb[2] ^ eb[3] ^ eb[4] ^ eb[5];
`endif
        for (int b = 0; b < NB; b++) begin
            if (cap.size() == 0) begin
                chk($sformatf("%s.b%0d_missing", tag, b), 64'd0, 64'd1);
            end else begin
                w = cap.pop_front();
                chk($sformatf("%s.b%0d_data", tag, b), w[63:0], eb[b]);
                chk($sformatf("%s.b%0d_last", tag, b), 64'(w[64]), 64'(b == NB - 1));
            end
        end
    endtask

    logic [255:0] r [5];
    logic [255:0] q_data [$];
    logic [63:0]  q_id [$];
    logic [255:0] rd;
    logic [63:0]  model_id, stall_word;
    int sent, base, t0, k;

    initial begin
        areset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        iq_first = 1'b0; counter_id = '0; m_tready = 1'b1;

        // 1: reset values, single report latency and layout
        step(); step();
        chk("rst.tready", 64'(s_tready), 64'd0);
        chk("rst.tvalid", 64'(m_tvalid), 64'd0);
        chk("rst.tkeep", 64'(m_tkeep), 64'd0);
        chk("rst.drop", 64'(drop_count), 64'd0);
        chk("rst.rcount", 64'(report_count), 64'd0);
        areset = 1'b0;
        step();
        cap.delete();
        chk("t1.tready", 64'(s_tready), 64'd1);
        iq_first = 1'b1; counter_id = 64'h1122;
        step();
        iq_first = 1'b0;
        rd = 256'hA000_0000_0000_0004_A000_0000_0000_0003_A000_0000_0000_0002_A000_0000_0000_0001;
        send(rd);
        chk("t1.n1_tvalid", 64'(m_tvalid), 64'd0);
        step();
        chk("t1.n2_tvalid", 64'(m_tvalid), 64'd0);
        step();
        chk("t1.n3_tvalid", 64'(m_tvalid), 64'd1);
        chk("t1.n3_tdata", m_tdata, 64'h504b504b_00000000);
        chk("t1.n3_tkeep", 64'(m_tkeep), 64'hFF);
        wait_beats(NB, 50, "t1");
        check_pkt("t1", 32'd0, 64'h1122, rd);
        step();
        chk("t1.rcount", 64'(report_count), 64'd1);

        // 2: stall downstream, overfill by one, then drain in order
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r[i] = {8{32'hB000_0000 + 32'(i)}};
            send(r[i]);
        end
        chk("t2.drop", 64'(drop_count), 64'd1);
        stall_word = m_tdata;
        chk("t2.stall_hdr", stall_word, 64'h504b504b_00000000);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t2.stall_tvalid", 64'(m_tvalid), 64'd1);
            chk("t2.stall_tdata", m_tdata, 64'h504b504b_00000000);
        end
        m_tready = 1'b1;
        wait_beats(4 * NB, 300, "t2");
        for (int i = 0; i < 4; i++) check_pkt($sformatf("t2.p%0d", i), 32'(i), 64'd0, r[i]);
        step();
        chk("t2.rcount", 64'(report_count), 64'd4);
        chk("t2.drop_end", 64'(drop_count), 64'd1);

        // 3: write into a full FIFO on the final-beat handshake is accepted
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r[i] = {8{32'hC000_0000 + 32'(i)}};
            send(r[i]);
        end
        step(); step();
        m_tready = 1'b1;
        k = 0;
        while (!(m_tvalid && m_tlast) && k < 60) begin
            step();
            k++;
        end
        chk("t3.found_last", 64'(m_tvalid && m_tlast), 64'd1);
        r[4] = {8{32'hCEEE_0004}};
        send(r[4]);
        chk("t3.drop", 64'(drop_count), 64'd0);
        wait_beats(5 * NB, 400, "t3");
        for (int i = 0; i < 5; i++) check_pkt($sformatf("t3.p%0d", i), 32'(i), 64'd0, r[i]);

        // 4: iq_first coincident with a report write stores the previous id
        do_reset();
        iq_first = 1'b1; counter_id = 64'd7;
        step();
        counter_id = 64'd5;
        r[0] = {8{32'hD000_0000}};
        send(r[0]);
        iq_first = 1'b0;
        r[1] = {8{32'hD000_0001}};
        send(r[1]);
        wait_beats(2 * NB, 200, "t4");
        check_pkt("t4.p0", 32'd0, 64'd7, r[0]);
        check_pkt("t4.p1", 32'd1, 64'd5, r[1]);

        // 5: reset mid-packet abandons it with no tlast
        do_reset();
        t0 = tlast_cnt;
        r[0] = {8{32'hE000_0000}};
        send(r[0]);
        k = 0;
        while (!(m_tvalid && m_tdata == r[0][63:0]) && k < 40) begin
            step();
            k++;
        end
        chk("t5.at_beat3", m_tdata, r[0][63:0]);
        areset = 1'b1;
        step();
        chk("t5.tvalid", 64'(m_tvalid), 64'd0);
        chk("t5.tlast", 64'(m_tlast), 64'd0);
        chk("t5.tdata", m_tdata, 64'd0);
        chk("t5.tkeep", 64'(m_tkeep), 64'd0);
        chk("t5.rcount", 64'(report_count), 64'd0);
        chk("t5.no_tlast", 64'(tlast_cnt - t0), 64'd0);
        areset = 1'b0;
        step();
        cap.delete();
        for (int i = 0; i < 30; i++) step();
        chk("t5.fifo_empty", 64'(cap.size()), 64'd0);
        r[1] = {8{32'hE000_0001}};
        send(r[1]);
        wait_beats(NB, 50, "t5");
        check_pkt("t5.p0", 32'd0, 64'd0, r[1]);

        // 6: random downstream backpressure and id changes over 100 packets
        do_reset();
        base = tlast_cnt;
        sent = 0;
        model_id = '0;
        k = 0;
        while (sent < 100 && k < 20000) begin
            m_tready = 1'($urandom_range(0, 1));
            iq_first = ($urandom_range(0, 3) == 0);
            counter_id = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) rd[32*i +: 32] = $urandom;
            s_tdata  = rd;
            s_tvalid = ((sent - (tlast_cnt - base)) < 4) && ($urandom_range(0, 1) == 1);
            if (s_tvalid) begin
                q_data.push_back(rd);
                q_id.push_back(model_id);
                sent++;
            end
            if (iq_first) model_id = counter_id;
            step();
            k++;
        end
        s_tvalid = 1'b0;
        iq_first = 1'b0;
        k = 0;
        while ((tlast_cnt - base) < 100 && k < 20000) begin
            m_tready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        m_tready = 1'b1;
        step();
        chk("t6.sent", 64'(sent), 64'd100);
        chk("t6.rcount", 64'(report_count), 64'd100);
        chk("t6.drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 100; i++) begin
            if (q_data.size() != 0)
                check_pkt($sformatf("t6.p%0d", i), 32'(i), q_id.pop_front(), q_data.pop_front());
        end
        chk("t6.leftover", 64'(cap.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
